apu_frame_sequencer: RTL and testbench

//  2A03 APU frame counter: schedules the APU datapath. Counts CPU-rate ticks and issues

---
 rtl/apu_frame_sequencer_pkg.sv | 29 ++
 rtl/apu_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_apu_frame_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apu_frame_sequencer_pkg.sv
// Shared constants and $4017 decode helpers for the APU frame sequencer.
package apu_frame_sequencer_pkg;

    // Default step positions in CPU ticks (NTSC 2A03 timing).
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_STEP1    = 7457;
    localparam int DEF_STEP2    = 14913;
    localparam int DEF_STEP3    = 22371;
    localparam int DEF_STEP4    = 29829;
    localparam int DEF_STEP5    = 37281;
    localparam int DEF_WR_DELAY = 3;

    // $4017 bit positions.
    localparam int FC_MODE_BIT    = 7;
    localparam int FC_INHIBIT_BIT = 6;

    typedef struct packed {
        logic mode_5step;
        logic irq_inhibit;
    } fc_cfg_t;

    function automatic fc_cfg_t decode_cfg(input logic [7:0] data);
        fc_cfg_t cfg;
        cfg.mode_5step  = data[FC_MODE_BIT];
        cfg.irq_inhibit = data[FC_INHIBIT_BIT];
        return cfg;
    endfunction

endpackage

// File: rtl/apu_frame_sequencer.sv
// 2A03 frame counter: step counter, $4017 register with delayed counter
// restart, quarter/half-frame strobes and the frame IRQ flag.
module apu_frame_sequencer
    import apu_frame_sequencer_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int STEP1    = DEF_STEP1,
    parameter int STEP2    = DEF_STEP2,
    parameter int STEP3    = DEF_STEP3,
    parameter int STEP4    = DEF_STEP4,
    parameter int STEP5    = DEF_STEP5,
    parameter int WR_DELAY = DEF_WR_DELAY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       apu_tick,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       irq_ack,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode_5step
);

    localparam int DLY_W = $clog2(WR_DELAY + 1);

    logic [CNT_W-1:0] cnt;
    logic [DLY_W-1:0] dly;
    logic             pend;
    logic             inhibit;
    fc_cfg_t          wr_cfg;

    logic m1, m2, m3, m4, m5;
    logic ev_q, ev_h, ev_irq, wrap;
    logic dly_tick, expire, irq_set;

    assign wr_cfg = decode_cfg(wr_data);

    assign m1 = (cnt == CNT_W'(STEP1));
    assign m2 = (cnt == CNT_W'(STEP2));
    assign m3 = (cnt == CNT_W'(STEP3));
    assign m4 = (cnt == CNT_W'(STEP4));
    assign m5 = (cnt == CNT_W'(STEP5));

    // A tick in the same clk as a write belongs to the old configuration and
    // does not consume any of the new delay.
    assign dly_tick = apu_tick && pend && !wr_en;
    assign expire   = dly_tick && (dly == DLY_W'(1));
    assign irq_set  = apu_tick && !expire && ev_irq && !inhibit;

    // Step decode for the current mode; wrap uses >= so the counter can never
    // run past the last step even after a mode change mid-sequence.
    always_comb begin
        ev_q   = 1'b0;
        ev_h   = 1'b0;
        ev_irq = 1'b0;
        wrap   = 1'b0;
        if (mode_5step) begin
            ev_q = m1 | m2 | m3 | m5;
            ev_h = m2 | m5;
            wrap = (cnt >= CNT_W'(STEP5));
        end else begin
            ev_q   = m1 | m2 | m3 | m4;
            ev_h   = m2 | m4;
            ev_irq = m4;
            wrap   = (cnt >= CNT_W'(STEP4));
        end
    end

    // Step counter: advance per tick, restart at the final step or on delay expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (apu_tick) begin
            if (expire || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // $4017 configuration and the delayed-restart down-counter (last write wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_5step <= 1'b0;
            inhibit    <= 1'b0;
            dly        <= '0;
            pend       <= 1'b0;
        end else if (wr_en) begin
            mode_5step <= wr_cfg.mode_5step;
            inhibit    <= wr_cfg.irq_inhibit;
            dly        <= DLY_W'(WR_DELAY);
            pend       <= 1'b1;
        end else if (dly_tick) begin
            dly <= dly - DLY_W'(1);
            if (expire) begin
                pend <= 1'b0;
            end
        end
    end

    // Registered strobes; delay expiry replaces any step event with Q+H in 5-step mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            quarter_frame <= apu_tick && (expire ? mode_5step : ev_q);
            half_frame    <= apu_tick && (expire ? mode_5step : ev_h);
        end
    end

    // Frame IRQ flag: inhibit write beats set, set beats acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_irq <= 1'b0;
        end else if (wr_en && wr_cfg.irq_inhibit) begin
            frame_irq <= 1'b0;
        end else if (irq_set) begin
            frame_irq <= 1'b1;
        end else if (irq_ack) begin
            frame_irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with shortened step positions.
module tb_apu_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       apu_tick;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       irq_ack;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode_5step;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apu_frame_sequencer #(
        .CNT_W(16), .STEP1(4), .STEP2(8), .STEP3(12), .STEP4(16), .STEP5(20),
        .WR_DELAY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .apu_tick(apu_tick), .wr_en(wr_en),
        .wr_data(wr_data), .irq_ack(irq_ack), .quarter_frame(quarter_frame),
        .half_frame(half_frame), .frame_irq(frame_irq), .mode_5step(mode_5step)
    );

    // Counter must never pass the 5-step wrap point.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (dut.cnt > 16'd20) begin
                failures++;
                $display("FAIL cnt_range cnt=%0d limit=20", dut.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; apu_tick = 1'b0; wr_en = 1'b0; wr_data = 8'h00; irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (quarter_frame !== 1'b0) begin failures++; $display("FAIL reset_q got=%b exp=0", quarter_frame); end
        if (half_frame !== 1'b0)    begin failures++; $display("FAIL reset_h got=%b exp=0", half_frame); end
        if (frame_irq !== 1'b0)     begin failures++; $display("FAIL reset_irq got=%b exp=0", frame_irq); end
        if (mode_5step !== 1'b0)    begin failures++; $display("FAIL reset_mode got=%b exp=0", mode_5step); end
        rst_n = 1'b1;
        apu_tick = 1'b1;
    endtask

    // Ticks 1..17 from cnt=0 in 4-step mode (tick t sees cnt=t-1).
    task automatic test_four_step(input string tag);
        logic eq, eh, ei;
        for (int t = 1; t <= 17; t++) begin
            step();
            eq = (t == 5) || (t == 9) || (t == 13) || (t == 17);
            eh = (t == 9) || (t == 17);
            ei = (t == 17);
            checks += 4;
            if (quarter_frame !== eq) begin failures++; $display("FAIL %s_q tick=%0d got=%b exp=%b", tag, t, quarter_frame, eq); end
            if (half_frame !== eh)    begin failures++; $display("FAIL %s_h tick=%0d got=%b exp=%b", tag, t, half_frame, eh); end
            if (frame_irq !== ei)     begin failures++; $display("FAIL %s_irq tick=%0d got=%b exp=%b", tag, t, frame_irq, ei); end
            if (mode_5step !== 1'b0)  begin failures++; $display("FAIL %s_mode tick=%0d got=%b exp=0", tag, t, mode_5step); end
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks += 2;
        if (frame_irq !== 1'b0)     begin failures++; $display("FAIL %s_ack got=%b exp=0", tag, frame_irq); end
        if (quarter_frame !== 1'b0) begin failures++; $display("FAIL %s_ack_q got=%b exp=0", tag, quarter_frame); end
    endtask

    // Write 0x80 at k=0 (cnt=1); expiry at k=3 gives Q+H, then 5-step schedule.
    task automatic test_five_step();
        logic eq, eh;
        wr_en = 1'b1; wr_data = 8'h80;
        step();
        wr_en = 1'b0;
        checks += 2;
        if (mode_5step !== 1'b1)    begin failures++; $display("FAIL five_mode got=%b exp=1", mode_5step); end
        if (quarter_frame !== 1'b0) begin failures++; $display("FAIL five_q k=0 got=%b exp=0", quarter_frame); end
        for (int k = 1; k <= 24; k++) begin
            step();
            eq = (k == 3) || (k == 8) || (k == 12) || (k == 16) || (k == 24);
            eh = (k == 3) || (k == 12) || (k == 24);
            checks += 3;
            if (quarter_frame !== eq) begin failures++; $display("FAIL five_q k=%0d got=%b exp=%b", k, quarter_frame, eq); end
            if (half_frame !== eh)    begin failures++; $display("FAIL five_h k=%0d got=%b exp=%b", k, half_frame, eh); end
            if (frame_irq !== 1'b0)   begin failures++; $display("FAIL five_irq k=%0d got=%b exp=0", k, frame_irq); end
        end
    endtask

    // Back to 4-step; irq_ack coincides with the STEP4 set at k=20, later ack clears.
    task automatic test_irq_ack();
        logic eq, eh, ei;
        wr_en = 1'b1; wr_data = 8'h00;
        step();
        wr_en = 1'b0;
        checks += 1;
        if (mode_5step !== 1'b0) begin failures++; $display("FAIL ack_mode got=%b exp=0", mode_5step); end
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) irq_ack = 1'b1;
            step();
            irq_ack = 1'b0;
            eq = (k == 8) || (k == 12) || (k == 16) || (k == 20);
            eh = (k == 12) || (k == 20);
            ei = (k == 20);
            checks += 3;
            if (quarter_frame !== eq) begin failures++; $display("FAIL ack_q k=%0d got=%b exp=%b", k, quarter_frame, eq); end
            if (half_frame !== eh)    begin failures++; $display("FAIL ack_h k=%0d got=%b exp=%b", k, half_frame, eh); end
            if (frame_irq !== ei)     begin failures++; $display("FAIL ack_irq k=%0d got=%b exp=%b", k, frame_irq, ei); end
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks += 1;
        if (frame_irq !== 1'b0) begin failures++; $display("FAIL ack_clear got=%b exp=0", frame_irq); end
    endtask

    // Wait for the next IRQ, write 0x40, then a full sequence with IRQ suppressed.
    task automatic test_inhibit();
        logic found, eq, eh;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (frame_irq === 1'b1) found = 1'b1;
        end
        checks += 1;
        if (!found) begin failures++; $display("FAIL inh_wait_irq got=0 exp=1 within 40 ticks"); end
        wr_en = 1'b1; wr_data = 8'h40;
        step();
        wr_en = 1'b0;
        checks += 1;
        if (frame_irq !== 1'b0) begin failures++; $display("FAIL inh_clear got=%b exp=0", frame_irq); end
        for (int k = 1; k <= 23; k++) begin
            step();
            eq = (k == 8) || (k == 12) || (k == 16) || (k == 20);
            eh = (k == 12) || (k == 20);
            checks += 3;
            if (quarter_frame !== eq) begin failures++; $display("FAIL inh_q k=%0d got=%b exp=%b", k, quarter_frame, eq); end
            if (half_frame !== eh)    begin failures++; $display("FAIL inh_h k=%0d got=%b exp=%b", k, half_frame, eh); end
            if (frame_irq !== 1'b0)   begin failures++; $display("FAIL inh_irq k=%0d got=%b exp=0", k, frame_irq); end
        end
    endtask

    // 0x00 at k=0 (cnt=3), 0x80 at k=1 (sees cnt=4 -> Q); single restart at k=4.
    task automatic test_back_to_back();
        logic eq, eh;
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) begin wr_en = 1'b1; wr_data = 8'h00; end
            if (k == 1) begin wr_en = 1'b1; wr_data = 8'h80; end
            step();
            wr_en = 1'b0;
            eq = (k == 1) || (k == 4) || (k == 9);
            eh = (k == 4);
            checks += 3;
            if (quarter_frame !== eq) begin failures++; $display("FAIL b2b_q k=%0d got=%b exp=%b", k, quarter_frame, eq); end
            if (half_frame !== eh)    begin failures++; $display("FAIL b2b_h k=%0d got=%b exp=%b", k, half_frame, eh); end
            if (frame_irq !== 1'b0)   begin failures++; $display("FAIL b2b_irq k=%0d got=%b exp=0", k, frame_irq); end
        end
    endtask

    // Run to cnt=10 with a write pending, reset asynchronously, then 4-step restart.
    task automatic test_async_reset();
        logic eq;
        for (int k = 10; k <= 14; k++) begin
            if (k == 14) begin wr_en = 1'b1; wr_data = 8'h80; end
            step();
            wr_en = 1'b0;
            eq = (k == 13);
            checks += 2;
            if (quarter_frame !== eq) begin failures++; $display("FAIL ar_q k=%0d got=%b exp=%b", k, quarter_frame, eq); end
            if (half_frame !== eq)    begin failures++; $display("FAIL ar_h k=%0d got=%b exp=%b", k, half_frame, eq); end
        end
        checks += 1;
        if (mode_5step !== 1'b1) begin failures++; $display("FAIL ar_mode_pre got=%b exp=1", mode_5step); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (quarter_frame !== 1'b0) begin failures++; $display("FAIL ar_q_now got=%b exp=0", quarter_frame); end
        if (half_frame !== 1'b0)    begin failures++; $display("FAIL ar_h_now got=%b exp=0", half_frame); end
        if (frame_irq !== 1'b0)     begin failures++; $display("FAIL ar_irq_now got=%b exp=0", frame_irq); end
        if (mode_5step !== 1'b0)    begin failures++; $display("FAIL ar_mode_now got=%b exp=0", mode_5step); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_four_step("post_rst");
    endtask

    initial begin
        test_reset();
        test_four_step("four");
        test_five_step();
        test_irq_ack();
        test_inhibit();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
